// File: rtl/maxpool_flatten.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_flatten
// Purpose  : streaming 2x2 signed max-pool; publishes the flattened pooled
//            frame with a one-cycle valid pulse. Optional macro POOL_RELU_EN
//            clamps each accepted pixel to >= 0 before pooling.
// Revision : 1.0
// ============================================================================
module maxpool_flatten #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] pixel_in,
  input  logic                     valid_in,
  input  logic                     sof_in,
  output logic signed [DATA_W-1:0] pooled_vec [0:(IMG_W/2)*(IMG_H/2)-1],
  output logic                     valid_out,
  output logic                     frame_err
);

  localparam int HALF_W = IMG_W / 2;
  localparam int N_OUT  = HALF_W * (IMG_H / 2);
  localparam int C_W    = $clog2(IMG_W);
  localparam int R_W    = $clog2(IMG_H);
  localparam int HI_W   = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int OI_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [R_W-1:0]          r_q, r_d;
  logic [C_W-1:0]          c_q, c_d;
  logic signed [DATA_W-1:0] h_q, h_d;
  logic signed [DATA_W-1:0] rowbuf_q [0:HALF_W-1];
  logic signed [DATA_W-1:0] rowbuf_d [0:HALF_W-1];
  logic signed [DATA_W-1:0] outbuf_q [0:N_OUT-1];
  logic signed [DATA_W-1:0] outbuf_d [0:N_OUT-1];
  logic signed [DATA_W-1:0] pooled_q [0:N_OUT-1];
  logic signed [DATA_W-1:0] pooled_d [0:N_OUT-1];
  logic                    valid_out_q, valid_out_d;
  logic                    frame_err_q, frame_err_d;

  logic                    w_start;
  logic                    w_err;
  logic                    w_step;
  logic                    w_final;
  logic                    w_last;
  logic signed [DATA_W-1:0] w_px;
  logic signed [DATA_W-1:0] w_hmax;
  logic signed [DATA_W-1:0] w_win;
  logic [HI_W-1:0]         w_hidx;
  logic [OI_W-1:0]         w_oidx;

`ifdef POOL_RELU_EN
  assign w_px = pixel_in[DATA_W-1] ? '0 : pixel_in;
`else
  assign w_px = pixel_in;
`endif

  assign w_last = (r_q == R_W'(IMG_H - 1)) && (c_q == C_W'(IMG_W - 1));
  assign w_hidx = HI_W'(c_q >> 1);
  assign w_oidx = OI_W'((32'(r_q) >> 1) * HALF_W + (32'(c_q) >> 1));
  assign w_hmax = (w_px > h_q) ? w_px : h_q;
  assign w_win  = (rowbuf_q[w_hidx] > w_hmax) ? rowbuf_q[w_hidx] : w_hmax;

  always_ff @(posedge clk or negedge reset_n) begin : p_state_reg
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : p_next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_in && sof_in) state_d = S_ACCUM;
      S_ACCUM: if (valid_in && !sof_in && w_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A sof pixel always lands on (0,0), whether it opens or restarts a frame.
  always_comb begin : p_fsm_outputs
    w_start = 1'b0;
    w_err   = 1'b0;
    w_step  = 1'b0;
    w_final = 1'b0;
    case (state_q)
      S_IDLE: begin
        w_start = valid_in && sof_in;
      end
      S_ACCUM: begin
        if (valid_in) begin
          if (sof_in) begin
            w_start = 1'b1;
            w_err   = 1'b1;
          end else begin
            w_step  = 1'b1;
            w_final = w_last;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin : p_datapath
    r_d         = r_q;
    c_d         = c_q;
    h_d         = h_q;
    rowbuf_d    = rowbuf_q;
    outbuf_d    = outbuf_q;
    pooled_d    = pooled_q;
    valid_out_d = w_final;
    frame_err_d = w_err;

    if (w_start) begin
      h_d = w_px;
      r_d = '0;
      c_d = C_W'(1);
    end else if (w_step) begin
      if (!c_q[0]) begin
        h_d = w_px;
      end else if (!r_q[0]) begin
        rowbuf_d[w_hidx] = w_hmax;
      end else begin
        outbuf_d[w_oidx] = w_win;
      end

      // Publish includes the window completed by this very pixel.
      if (w_final) begin
        pooled_d = outbuf_d;
        r_d      = '0;
        c_d      = '0;
      end else if (c_q == C_W'(IMG_W - 1)) begin
        c_d = '0;
        r_d = r_q + R_W'(1);
      end else begin
        c_d = c_q + C_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_data_reg
    if (!reset_n) begin
      r_q         <= '0;
      c_q         <= '0;
      h_q         <= '0;
      rowbuf_q    <= '{default: '0};
      outbuf_q    <= '{default: '0};
      pooled_q    <= '{default: '0};
      valid_out_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      r_q         <= r_d;
      c_q         <= c_d;
      h_q         <= h_d;
      rowbuf_q    <= rowbuf_d;
      outbuf_q    <= outbuf_d;
      pooled_q    <= pooled_d;
      valid_out_q <= valid_out_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign pooled_vec = pooled_q;
  assign valid_out  = valid_out_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_flatten.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_flatten
// Purpose  : scoreboard bench for maxpool_flatten (directed + random frames)
// Revision : 1.0
// ============================================================================
module tb_maxpool_flatten;

  localparam int DATA_W = 16;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int N      = (IMG_W / 2) * (IMG_H / 2);
  localparam int NPIX   = IMG_W * IMG_H;

  typedef logic signed [DATA_W-1:0] pix_t;
  typedef logic [N*DATA_W-1:0]      vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  pix_t pixel_in = '0;
  logic valid_in = 1'b0;
  logic sof_in = 1'b0;
  pix_t pooled_vec [0:N-1];
  logic valid_out;
  logic frame_err;

  maxpool_flatten #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_in   (pixel_in),
    .valid_in   (valid_in),
    .sof_in     (sof_in),
    .pooled_vec (pooled_vec),
    .valid_out  (valid_out),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   in_frame = 1'b0;
  pix_t cur [$];
  vec_t exp_vq [$];
  int   exp_cq [$];
  int   exp_eq [$];
  vec_t exp_hold = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic vec_t pack_dut();
    vec_t v = '0;
    for (int i = 0; i < N; i++) v[i*DATA_W +: DATA_W] = pooled_vec[i];
    return v;
  endfunction

  function automatic pix_t relu(input pix_t p);
`ifdef POOL_RELU_EN
    return (p < 0) ? pix_t'(0) : p;
`else
    return p;
`endif
  endfunction

  // Reference: max over each non-overlapping 2x2 window of the stored frame.
  function automatic vec_t ref_pool();
    vec_t v = '0;
    for (int wr = 0; wr < IMG_H / 2; wr++) begin
      for (int wc = 0; wc < IMG_W / 2; wc++) begin
        pix_t m = cur[(2*wr)*IMG_W + 2*wc];
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            pix_t p = cur[(2*wr+dr)*IMG_W + 2*wc + dc];
            if (p > m) m = p;
          end
        end
        v[(wr*(IMG_W/2) + wc)*DATA_W +: DATA_W] = m;
      end
    end
    return v;
  endfunction

  // Model of one accepted pixel; sampled on the edge that makes cyc = cyc+1.
  function automatic void model_accept(input bit s, input pix_t p);
    if (s) begin
      if (in_frame) exp_eq.push_back(cyc + 1);
      in_frame = 1'b1;
      cur.delete();
      cur.push_back(relu(p));
    end else if (in_frame) begin
      cur.push_back(relu(p));
      if (cur.size() == NPIX) begin
        exp_vq.push_back(ref_pool());
        exp_cq.push_back(cyc + 1);
        in_frame = 1'b0;
      end
    end
  endfunction

  task automatic drive(input bit v, input bit s, input pix_t p);
    @(negedge clk);
    valid_in = v;
    sof_in   = s;
    pixel_in = p;
    if (v) model_accept(s, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  function automatic pix_t gen(input int kind, input int i);
    case (kind)
      0: return pix_t'(i);
      1: return pix_t'(-i);
      2: return pix_t'(7);
      4: return pix_t'(100);
      5: return (i == 1) ? pix_t'(16'sh7FFF) :
                ((i == 0 || i == 4 || i == 5) ? pix_t'(16'sh8000) : pix_t'(0));
      default: return pix_t'($urandom);
    endcase
  endfunction

  // gapmode: 0 back-to-back, 1 valid toggles every cycle, 2 random gaps
  task automatic send_frame(input int kind, input int npix, input int gapmode);
    for (int i = 0; i < npix; i++) begin
      if (gapmode == 1 && i > 0) drive(1'b0, 1'b0, '0);
      if (gapmode == 2)
        while ($urandom_range(0, 3) == 0) drive(1'b0, 1'($urandom_range(0, 1)), pix_t'($urandom));
      drive(1'b1, i == 0, gen(kind, i));
    end
  endtask

  // Monitor: pops expectations when the DUT pulses, else checks hold.
  always @(negedge clk) begin
    vec_t av;
    vec_t ev;
    int   ec;
    if (!reset_n) exp_hold = '0;
    av = pack_dut();
    if (exp_cq.size() > 0 && exp_cq[0] < cyc) begin
      chk("valid_out_missing", vec_t'(0), vec_t'(exp_cq[0]));
      void'(exp_cq.pop_front());
      exp_hold = exp_vq.pop_front();
    end
    if (valid_out) begin
      if (exp_vq.size() == 0) begin
        chk("valid_out_unexpected", vec_t'(1), vec_t'(0));
      end else begin
        ev = exp_vq.pop_front();
        ec = exp_cq.pop_front();
        chk("pooled_vec", av, ev);
        chk("valid_out_cycle", vec_t'(cyc), vec_t'(ec));
        exp_hold = ev;
      end
    end else begin
      chk("pooled_hold", av, exp_hold);
    end
    if (exp_eq.size() > 0 && exp_eq[0] < cyc) begin
      chk("frame_err_missing", vec_t'(0), vec_t'(exp_eq[0]));
      void'(exp_eq.pop_front());
    end
    if (frame_err) begin
      if (exp_eq.size() == 0) begin
        chk("frame_err_unexpected", vec_t'(1), vec_t'(0));
      end else begin
        ec = exp_eq.pop_front();
        chk("frame_err_cycle", vec_t'(cyc), vec_t'(ec));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t asc;
    vec_t neg;
    vec_t sev;
    vec_t v;
    pix_t p0;
    asc = {16'sd15, 16'sd13, 16'sd7, 16'sd5};
    sev = {16'sd7, 16'sd7, 16'sd7, 16'sd7};
`ifdef POOL_RELU_EN
    neg = '0;
`else
    neg = {-16'sd10, -16'sd8, -16'sd2, 16'sd0};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pooled", pack_dut(), '0);
    chk("reset_valid_out", vec_t'(valid_out), '0);
    chk("reset_frame_err", vec_t'(frame_err), '0);
    @(negedge clk);
    reset_n = 1'b1;

    send_frame(0, NPIX, 0);
    idle(3);
    chk("ascending_const", pack_dut(), asc);

    send_frame(1, NPIX, 0);
    idle(3);
    chk("negated_const", pack_dut(), neg);

    send_frame(5, NPIX, 0);
    idle(3);
    v  = pack_dut();
    p0 = v[DATA_W-1:0];
    chk("extreme_max", vec_t'(p0), vec_t'(16'h7FFF));

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, pix_t'($urandom));
    send_frame(0, NPIX, 1);
    idle(3);
    chk("gapped_const", pack_dut(), asc);

    send_frame(4, 6, 0);
    send_frame(0, NPIX, 0);
    idle(3);
    chk("restart_const", pack_dut(), asc);

    send_frame(0, 9, 0);
    idle(1);
    @(posedge clk);
    #2;
    reset_n  = 1'b0;
    in_frame = 1'b0;
    #1;
    chk("midreset_pooled", pack_dut(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    send_frame(0, NPIX, 0);
    idle(3);
    chk("after_reset_const", pack_dut(), asc);

    send_frame(0, NPIX, 0);
    send_frame(2, NPIX, 0);
    idle(3);
    chk("back_to_back_const", pack_dut(), sev);

    send_frame(3, NPIX - 1, 0);
    send_frame(0, NPIX, 0);
    idle(2);

    for (int it = 0; it < 25; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        send_frame(3, $urandom_range(1, NPIX), 2);
      end else if (sel == 2) begin
        drive(1'b1, 1'b0, pix_t'($urandom));
      end else begin
        send_frame(3, NPIX, 2);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
    end
    send_frame(3, NPIX, 0);
    idle(5);

    chk("vec_queue_drained", vec_t'(exp_vq.size()), '0);
    chk("err_queue_drained", vec_t'(exp_eq.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maxpool_flatten.md
# maxpool_flatten

Streaming 2x2 max-pooling stage that sits directly upstream of the fully-connected layer. It consumes the convolution feature map one signed pixel per accepted cycle in raster order. It reduces each non-overlapping 2x2 window to its maximum and presents the flattened pooled vector, with a one-cycle valid pulse, in the form the FC layer's `input_vec`/`valid_in` expect.

## Interface
- `DATA_W`, 16, signed pixel/output width
- `IMG_W`, 4, feature-map width in pixels; even, ≥2
- `IMG_H`, 4, feature-map height in pixels; even, ≥2
- `clk`  in  1  single clock; all logic on rising edge
- `reset_n`  in  1  reset; asynchronous and active-low
- `pixel_in`  in  DATA_W  signed feature-map pixel
- `valid_in`  in  1  `pixel_in` is sampled on this edge
- `sof_in`  in  1  start of frame; qualified by `valid_in`; marks pixel (0,0)
- `pooled_vec[0:N-1]`  out  DATA_W each  pooled outputs
  - N = (IMG_W/2)·(IMG_H/2); index = (r/2)·(IMG_W/2) + c/2
- `valid_out`  out  1  one-cycle pulse; `pooled_vec` holds a new complete frame
- `frame_err`  out  1  one-cycle pulse; frame restarted before completion

## Operation
- States:
  - IDLE: waiting for a frame.
  - ACCUM: inside a frame.
- Row counter r (0..IMG_H-1) and column counter c (0..IMG_W-1) advance only on accepted pixels (`valid_in`=1). Wrap order: c first, then r.
- IDLE:
  - `valid_in`&`sof_in` accepts the pixel as (0,0) and moves to ACCUM.
  - `valid_in` without `sof_in` is dropped silently.
- ACCUM, accepted pixel, by position:
  - even c: store in horizontal register h.
  - even r, odd c: write rowbuf[c/2] = max(h, pixel).
  - odd r, odd c: write outbuf[idx] = max(rowbuf[c/2], max(h, pixel)).
- All comparisons are signed, full DATA_W. No widening and no saturation: max never exceeds its inputs.
- Final pixel (r=IMG_H-1, c=IMG_W-1): copy outbuf, including the window just completed, into the `pooled_vec` registers. Pulse `valid_out`, return to IDLE, and clear r and c.
- `sof_in` with `valid_in` while in ACCUM, including on the position of the final pixel:
  - pulse `frame_err` and discard the partial frame; no `valid_out` for it.
  - accept the pixel as (0,0) of the new frame; stay in ACCUM.
- `valid_in`=0 cycles (gaps) freeze all state. Gaps of any length are legal.
- `pooled_vec` holds its last published frame until the next `valid_out`. rowbuf and outbuf are internal and never visible mid-frame.
- `sof_in` without `valid_in` is ignored.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - state IDLE; r, c, h, rowbuf, outbuf cleared.
  - all `pooled_vec` entries 0; `valid_out`=0; `frame_err`=0.
- Reset release is synchronous to `clk`. The first edge with `reset_n`=1 may accept a sof pixel.
- Latency: the final pixel is sampled at edge k; `pooled_vec` updates and `valid_out`=1 after edge k, for exactly one cycle.
- `frame_err` is asserted for the cycle after the edge that sampled the offending sof pixel.
- Throughput: one pixel per cycle, sustained. A sof pixel may arrive on the edge immediately after a final pixel, with no bubble needed.
- Reset mid-frame: the partial frame is lost, no `valid_out` is produced, and outputs read zero immediately.
- No backpressure: the downstream stage always accepts `valid_out`.

## Configuration
- `POOL_RELU_EN` defined: each accepted pixel is clamped to max(pixel, 0) before any comparison. All `pooled_vec` entries are ≥0.
- `POOL_RELU_EN` undefined: raw signed max pooling; negative outputs are possible.

## Test plan
- Ascending frame: 4x4 frame 0..15 raster with sof on pixel 0, back-to-back -> `pooled_vec`={5,7,13,15}; `valid_out` high exactly one cycle, the cycle after pixel 15 is sampled.
- Negated frame: pixels -(0..15) -> {0,-2,-8,-10} without `POOL_RELU_EN`; {0,0,0,0} with it. Also 16'sh7FFF and 16'sh8000 in one window -> 16'sh7FFF.
- Gaps and stray pixels: ascending frame with `valid_in` toggling every cycle, preceded by 3 non-sof pixels in IDLE -> same {5,7,13,15}; stray pixels ignored; `valid_out` one cycle after pixel 15.
- Mid-frame restart: 6 pixels of 100s, then sof plus the full ascending frame -> one `frame_err` pulse after the second sof; a single `valid_out` with {5,7,13,15}.
- Reset mid-frame: `reset_n` low after 9 pixels -> `pooled_vec` all 0 and no `valid_out`; the next full ascending frame gives {5,7,13,15}.
- Back-to-back frames: ascending frame, then immediately a frame of all 7s -> two `valid_out` pulses 16 cycles apart; `pooled_vec` holds {5,7,13,15} until the second pulse, then {7,7,7,7}.
